// File: rtl/shift_reg_tx_ctrl_if.sv
// Client-side word handshake for the shift-register TX sequencer.
// The client drives valid/data/div; the controller returns ready.
interface shift_reg_tx_ctrl_if #(
  parameter int N     = 8,
  parameter int DIV_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic [DIV_W-1:0] div;

  modport master (output in_valid, in_data, div, input in_ready);
  modport slave  (input in_valid, in_data, div, output in_ready);
endinterface

// File: rtl/shift_reg_tx_ctrl.sv
// Sequences an external N-bit parallel-load / shift-left register.
// Each accepted word is presented MSB-first, one bit per (div+1) cycles.
module shift_reg_tx_ctrl #(
  parameter int   N          = 8,
  parameter int   DIV_W      = 8,
  parameter int   GAP_CYCLES = 2,
  parameter logic FILL       = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_reg_tx_ctrl_if.slave   client,
  input  logic                 abort,
  output logic                 sr_load_en,
  output logic                 sr_shift_en,
  output logic [N-1:0]         sr_p_in,
  output logic                 sr_s_in,
  output logic                 ser_valid,
  output logic [$clog2(N)-1:0] bit_idx,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_aborted
);

  localparam int IW = $clog2(N);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] div_lat_reg, div_lat_next;
  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic [IW-1:0]    bit_idx_reg, bit_idx_next;
  logic [GW-1:0]    gap_cnt_reg, gap_cnt_next;

  logic in_ready;
  logic accept;
  logic last_bit;
  logic bit_end;

  // Ready is held low during reset so no word can be taken while the FSM is cleared.
  assign in_ready = rst_n && (state_reg == IDLE) && !abort;
  assign accept   = client.in_valid && in_ready;
  assign last_bit = (bit_idx_reg == LAST_IDX);
  assign bit_end  = (state_reg == SHIFT) && !abort && (div_cnt_reg == '0);

  assign client.in_ready = in_ready;

  for (genvar gi = 0; gi < N; gi++) begin : g_p_in
    assign sr_p_in[gi] = client.in_data[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      div_lat_reg <= '0;
      div_cnt_reg <= '0;
      bit_idx_reg <= '0;
      gap_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      div_lat_reg <= div_lat_next;
      div_cnt_reg <= div_cnt_next;
      bit_idx_reg <= bit_idx_next;
      gap_cnt_reg <= gap_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    div_lat_next = div_lat_reg;
    div_cnt_next = div_cnt_reg;
    bit_idx_next = bit_idx_reg;
    gap_cnt_next = gap_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next   = SHIFT;
          div_lat_next = client.div;
          div_cnt_next = client.div;
          bit_idx_next = '0;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_next   = IDLE;
          div_cnt_next = '0;
          bit_idx_next = '0;
        end else if (div_cnt_reg != '0) begin
          div_cnt_next = div_cnt_reg - DIV_W'(1);
        end else if (!last_bit) begin
          // Reload from the latched period so mid-frame div changes are ignored.
          bit_idx_next = bit_idx_reg + IW'(1);
          div_cnt_next = div_lat_reg;
        end else begin
          bit_idx_next = '0;
          if (GAP_CYCLES > 0) begin
            state_next   = GAP;
            gap_cnt_next = GW'(GAP_CYCLES - 1);
          end else begin
            state_next = IDLE;
          end
        end
      end
      GAP: begin
        if (abort || gap_cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg - GW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sr_load_en    = accept;
    sr_shift_en   = bit_end && !last_bit;
    sr_s_in       = FILL;
    ser_valid     = (state_reg == SHIFT);
    bit_idx       = bit_idx_reg;
    busy          = (state_reg != IDLE);
    frame_done    = bit_end && last_bit;
    frame_aborted = (state_reg == SHIFT) && abort;
  end

endmodule
